cpu_run_ctrl: RTL and testbench

Execution controller that sits directly downstream of the front-panel button state machine. It consumes single-cycle command pulses (run, stop, step, reset) and the core's halt flag. It produces the clock enable and synchronous reset that pace the MIC-1 datapath, plus status flags for the LEDs and an executed-cycle counter. Free-run speed is set at build time by a clock-enable divider, so the same block serves full-speed operation and human-visible slow-clock demonstrations.

---
 rtl/mic1_ctrl_pkg.sv | 17 +
 rtl/cpu_ce_div.sv | 40 ++++
 rtl/cpu_run_ctrl.sv | 119 +++++++++++
 tb/tb_cpu_run_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mic1_ctrl_pkg.sv
// Shared types and build-time defaults for the MIC-1 run controller.
package mic1_ctrl_pkg;

    typedef enum logic [2:0] {
        StRstHold,
        StStopped,
        StRun,
        StStep,
        StHalted
    } run_state_t;

    localparam int unsigned CeDivDefault     = 1;
    localparam int unsigned RstCyclesDefault = 16;
    // Wide enough for a terminal count of 2^24-1.
    localparam int unsigned CeDivW           = 24;

endpackage

// File: rtl/cpu_ce_div.sv
// Loadable modulo-CeDiv counter; tc_o flags the last count before wrapping to zero.
module cpu_ce_div #(
    parameter int unsigned CeDiv = 1,
    parameter int unsigned Width = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             tc_o
);

    localparam logic [Width-1:0] Last = Width'(CeDiv - 1);

    logic [Width-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == Last);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/stop/step/reset controller pacing the MIC-1 datapath via a registered clock
// enable and synchronous reset, with status flags and an executed-cycle counter.
module cpu_run_ctrl
    import mic1_ctrl_pkg::*;
#(
    parameter int unsigned CE_DIV     = CeDivDefault,
    parameter int unsigned RST_CYCLES = RstCyclesDefault,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             cmd_run,
    input  logic             cmd_stop,
    input  logic             cmd_step,
    input  logic             cmd_reset,
    input  logic             cpu_halt,
    output logic             cpu_ce,
    output logic             cpu_rst_,
    output logic             running,
    output logic             stopped,
    output logic             halted,
    output logic             in_reset,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [7:0] RstLast = 8'(RST_CYCLES - 1);

    run_state_t       state_q, state_d;
    logic [7:0]       rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ce_q, ce_d;
    logic             rst_n_q, rst_n_d;
    logic             div_tc, div_clr, div_en;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRstHold: begin
                if (rst_cnt_q == RstLast) state_d = StStopped;
            end
            // STEP resolves its one cycle with STOPPED semantics.
            StStopped, StStep: begin
                if (cmd_reset)     state_d = StRstHold;
                else if (cpu_halt) state_d = StHalted;
                else if (cmd_stop) state_d = StStopped;
                else if (cmd_run)  state_d = StRun;
                else if (cmd_step) state_d = StStep;
                else               state_d = StStopped;
            end
            StRun: begin
                if (cmd_reset)     state_d = StRstHold;
                else if (cpu_halt) state_d = StHalted;
                else if (cmd_stop) state_d = StStopped;
            end
            StHalted: begin
                if (cmd_reset) state_d = StRstHold;
            end
            default: state_d = StRstHold;
        endcase
    end

    always_comb begin
        rst_cnt_d = '0;
        if (state_q == StRstHold && state_d == StRstHold) begin
            rst_cnt_d = rst_cnt_q + 8'd1;
        end

        // A pending pulse may finish on stop/halt, but never leaks into a reset hold.
        ce_d    = (state_d != StRstHold) &&
                  ((state_q == StRun && div_tc) || state_q == StStep);
        rst_n_d = (state_d != StRstHold);

        cnt_d = cnt_q + CNT_W'(ce_q);
        if (state_d == StRstHold && state_q != StRstHold) begin
            cnt_d = '0;
        end
    end

    assign div_en  = (state_q == StRun);
    assign div_clr = (state_d == StRun) && (state_q != StRun);

    cpu_ce_div #(
        .CeDiv(CE_DIV),
        .Width(CeDivW)
    ) u_ce_div (
        .clk_i     (clk),
        .rst_ni    (reset_),
        .clr_i     (div_clr),
        .en_i      (div_en),
        .load_i    (1'b0),
        .load_val_i('0),
        .tc_o      (div_tc)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q   <= StRstHold;
            rst_cnt_q <= '0;
            cnt_q     <= '0;
            ce_q      <= 1'b0;
            rst_n_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            cnt_q     <= cnt_d;
            ce_q      <= ce_d;
            rst_n_q   <= rst_n_d;
        end
    end

    assign cpu_ce    = ce_q;
    assign cpu_rst_  = rst_n_q;
    assign running   = (state_q == StRun);
    assign stopped   = (state_q == StStopped);
    assign halted    = (state_q == StHalted);
    assign in_reset  = (state_q == StRstHold);
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: three instances (CE_DIV 1 and 4, and a narrow
// counter for wrap) share one command stream.
module tb_cpu_run_ctrl;

    localparam logic [3:0] C_RST  = 4'b1000;
    localparam logic [3:0] C_STOP = 4'b0100;
    localparam logic [3:0] C_RUN  = 4'b0010;
    localparam logic [3:0] C_STEP = 4'b0001;

    logic clk = 1'b0;
    logic reset_, cmd_run, cmd_stop, cmd_step, cmd_reset, cpu_halt;

    logic        ce1, rstn1, run1, stp1, hlt1, inr1;
    logic [31:0] cnt1;
    logic        ce4, rstn4, run4, stp4, hlt4, inr4;
    logic [31:0] cnt4;
    logic        cew, rstnw, runw, stpw, hltw, inrw;
    logic [2:0]  cntw;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_t;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    cpu_run_ctrl #(.CE_DIV(1), .RST_CYCLES(4), .CNT_W(32)) u_dut1 (
        .clk(clk), .reset_(reset_), .cmd_run(cmd_run), .cmd_stop(cmd_stop),
        .cmd_step(cmd_step), .cmd_reset(cmd_reset), .cpu_halt(cpu_halt),
        .cpu_ce(ce1), .cpu_rst_(rstn1), .running(run1), .stopped(stp1),
        .halted(hlt1), .in_reset(inr1), .cycle_cnt(cnt1)
    );

    cpu_run_ctrl #(.CE_DIV(4), .RST_CYCLES(4), .CNT_W(32)) u_dut4 (
        .clk(clk), .reset_(reset_), .cmd_run(cmd_run), .cmd_stop(cmd_stop),
        .cmd_step(cmd_step), .cmd_reset(cmd_reset), .cpu_halt(cpu_halt),
        .cpu_ce(ce4), .cpu_rst_(rstn4), .running(run4), .stopped(stp4),
        .halted(hlt4), .in_reset(inr4), .cycle_cnt(cnt4)
    );

    cpu_run_ctrl #(.CE_DIV(1), .RST_CYCLES(4), .CNT_W(3)) u_dutw (
        .clk(clk), .reset_(reset_), .cmd_run(cmd_run), .cmd_stop(cmd_stop),
        .cmd_step(cmd_step), .cmd_reset(cmd_reset), .cpu_halt(cpu_halt),
        .cpu_ce(cew), .cpu_rst_(rstnw), .running(runw), .stopped(stpw),
        .halted(hltw), .in_reset(inrw), .cycle_cnt(cntw)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        sb_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        sb_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, got, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [3:0] c);
        {cmd_reset, cmd_stop, cmd_run, cmd_step} = c;
        tick();
        {cmd_reset, cmd_stop, cmd_run, cmd_step} = 4'b0000;
    endtask

    task automatic hold_len(output int k);
        k = 0;
        while (!rstn1 && k < 20) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_stopped(input string tag);
        int k = 0;
        while (!(stp1 && stp4 && stpw) && k < 20) begin
            tick();
            k++;
        end
        check_val(tag, 32'(stp1 && stp4 && stpw), 32'd1);
    endtask

    task automatic do_reset();
        int k;
        sb_push("rst_in_reset", 32'd1);
        sb_push("rst_cnt_clr", 32'd0);
        sb_push("rst_hold_len", 32'd4);
        send_cmd(C_RST);
        sb_pop(32'(inr1));
        sb_pop(cnt1);
        hold_len(k);
        sb_pop(32'(k));
        wait_stopped("rst_to_stopped");
    endtask

    initial begin
        int          k;
        int          ce_hi;
        logic [20:0] mask, exp_mask;
        logic [4:0]  pat;

        reset_ = 1'b0;
        {cmd_reset, cmd_stop, cmd_run, cmd_step} = 4'b0000;
        cpu_halt = 1'b0;

        // Reset values before any clock edge.
        sb_push("por_in_reset", 32'd1);
        sb_push("por_rst_n", 32'd0);
        sb_push("por_ce", 32'd0);
        sb_push("por_flags", 32'd0);
        sb_push("por_cnt", 32'd0);
        #2;
        sb_pop(32'(inr1));
        sb_pop(32'(rstn1));
        sb_pop(32'({ce1, ce4, cew}));
        sb_pop(32'({run1, stp1, hlt1}));
        sb_pop(cnt1);

        tick();
        tick();
        sb_push("por_hold_len", 32'd4);
        sb_push("por_stopped", 32'd1);
        sb_push("por_ce_after", 32'd0);
        sb_push("por_cnt_after", 32'd0);
        reset_ = 1'b1;
        hold_len(k);
        sb_pop(32'(k));
        sb_pop(32'(stp1));
        sb_pop(32'(ce1));
        sb_pop(cnt1);

        // Free run at CE_DIV=1 for 10 cycles, then stop.
        sb_push("run_running", 32'd1);
        sb_push("run_ce_cont", 32'd10);
        send_cmd(C_RUN);
        sb_pop(32'(run1));
        ce_hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ce1) ce_hi++;
        end
        sb_pop(32'(ce_hi));
        sb_push("stop_stopped", 32'd1);
        sb_push("stop_d1_cnt", 32'd11);
        sb_push("stop_d4_cnt", 32'd2);
        sb_push("stop_dw_wrap", 32'd3);
        sb_push("stop_ce_low", 32'd0);
        send_cmd(C_STOP);
        sb_pop(32'({run1, stp1}));
        tick();
        sb_pop(cnt1);
        sb_pop(cnt4);
        sb_pop(32'(cntw));
        repeat (3) tick();
        sb_pop(32'({ce1, ce4, cew}));

        // CE_DIV=4 pulse positions over 20 cycles.
        do_reset();
        exp_mask = '0;
        for (int j = 4; j <= 20; j += 4) exp_mask[j] = 1'b1;
        sb_push("div4_mask", 32'(exp_mask));
        sb_push("div4_cnt", 32'd5);
        sb_push("div4_d1_cnt", 32'd21);
        send_cmd(C_RUN);
        mask = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            mask[i] = ce4;
        end
        sb_pop(32'(mask));
        send_cmd(C_STOP);
        tick();
        sb_pop(cnt4);
        sb_pop(cnt1);

        // Three single steps spaced five cycles apart.
        do_reset();
        for (int s = 0; s < 3; s++) begin
            sb_push("step_pat", 32'd2);
            sb_push("step_back_stopped", 32'd1);
            send_cmd(C_STEP);
            pat[0] = ce1;
            for (int t = 1; t <= 4; t++) begin
                tick();
                pat[t] = ce1;
            end
            sb_pop(32'(pat));
            sb_pop(32'(stp1));
        end
        sb_push("step_cnt1", 32'd3);
        sb_push("step_cnt4", 32'd3);
        sb_pop(cnt1);
        sb_pop(cnt4);

        // Halt in RUN, then run/step ignored, then reset.
        do_reset();
        send_cmd(C_RUN);
        repeat (3) tick();
        sb_push("halt_flag", 32'd3);
        cpu_halt = 1'b1;
        tick();
        sb_pop(32'({hlt1, hlt4}));
        send_cmd(C_RUN);
        send_cmd(C_STEP);
        tick();
        sb_push("halt_stays", 32'd3);
        sb_push("halt_ce_off", 32'd0);
        sb_push("halt_cnt1", 32'd4);
        sb_push("halt_cnt4", 32'd1);
        sb_pop(32'({hlt1, hlt4}));
        sb_pop(32'({ce1, ce4}));
        sb_pop(cnt1);
        sb_pop(cnt4);
        sb_push("halt_rst_in_reset", 32'd1);
        sb_push("halt_rst_cnt", 32'd0);
        send_cmd(C_RST);
        cpu_halt = 1'b0;
        sb_pop(32'(inr1));
        sb_pop(cnt1);
        wait_stopped("halt_rst_stopped");

        // Simultaneous commands.
        sb_push("sim_rst_run", 32'd1);
        send_cmd(C_RST | C_RUN);
        sb_pop(32'({inr1, run1}) >> 1);
        wait_stopped("sim_rst_stopped");
        sb_push("sim_stop_run_idle", 32'd1);
        send_cmd(C_STOP | C_RUN);
        sb_pop(32'({run1, stp1}));
        sb_push("sim_run_step", 32'd2);
        send_cmd(C_RUN | C_STEP);
        sb_pop(32'({run1, stp1}));
        tick();
        sb_push("sim_stop_run_inrun", 32'd1);
        send_cmd(C_STOP | C_RUN);
        sb_pop(32'({run1, stp1}));

        // Asynchronous reset in the middle of a clock cycle while running.
        send_cmd(C_RUN);
        repeat (3) tick();
        sb_push("async_pre_ce", 32'd1);
        sb_pop(32'(ce1));
        sb_push("async_ce", 32'd0);
        sb_push("async_rst_n", 32'd0);
        sb_push("async_in_reset", 32'd1);
        sb_push("async_cnt", 32'd0);
        #3;
        reset_ = 1'b0;
        #1;
        sb_pop(32'({ce1, ce4, cew}));
        sb_pop(32'(rstn1));
        sb_pop(32'(inr1));
        sb_pop(cnt1);
        #3;
        reset_ = 1'b1;
        wait_stopped("async_recover");

        check_val("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
